// File: rtl/ecap5_dwbic_pkg.sv
// Shared constants and types for the ecap5 Wishbone 1:N decoder.
package ecap5_dwbic_pkg;

    localparam int unsigned DAT_W     = 32;
    localparam int unsigned SEL_BYTES = 4;

    // Tracker FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Master request payload broadcast to every slave port
    typedef struct packed {
        logic [DAT_W-1:0]     adr;
        logic [DAT_W-1:0]     dat;
        logic [SEL_BYTES-1:0] sel;
        logic                 we;
    } wb_req_t;

    // Width of the slave index field; targets are one bit wider so the
    // all-ones code can name the internal error target.
    function automatic int unsigned sel_width(input int unsigned num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

endpackage

// File: rtl/ecap5_dwbic_tracker.sv
// Outstanding-request tracker: count, locked target, ack timeout and drain FSM.
module ecap5_dwbic_tracker
    import ecap5_dwbic_pkg::*;
#(
    parameter int unsigned TGT_W           = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cyc,
    input  logic             accept_c,
    input  logic [TGT_W-1:0] dec_tgt_c,
    input  logic             slave_ack_c,
    output logic [TGT_W-1:0] target,
    output logic             busy_c,
    output logic             draining_c,
    output logic             tgt_err_c,
    output logic             stall_c,
    output logic             err_ack_c
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TGT_W-1:0] ERR_TGT = '1;

    logic [1:0]       state,   state_nxt;
    logic [CNT_W-1:0] out_cnt, cnt_nxt;
    logic [TGT_W-1:0] target_nxt;
    logic [TMR_W-1:0] timer,   timer_nxt;
    logic             full_c;
    logic             ret_c;
    logic             timeout_hit_c;

    assign busy_c        = (out_cnt != '0);
    assign full_c        = (out_cnt == CNT_W'(MAX_OUTSTANDING));
    assign draining_c    = (state == ST_DRAIN);
    assign tgt_err_c     = (target == ERR_TGT);
    // Slave stall is added by the top; these terms also gate slave strobes
    assign stall_c       = full_c | (busy_c & (dec_tgt_c != target)) | draining_c;
    // Error target and drain both return one ack+err per cycle while requests remain
    assign err_ack_c     = cyc & busy_c & (draining_c | tgt_err_c);
    assign ret_c         = slave_ack_c | err_ack_c;
    assign timeout_hit_c = (TIMEOUT_CYCLES != 0) && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            out_cnt <= '0;
            target  <= '0;
            timer   <= '0;
        end else begin
            state   <= state_nxt;
            out_cnt <= cnt_nxt;
            target  <= target_nxt;
            timer   <= timer_nxt;
        end
    end

    // Next-state: count, target lock, timeout and abort handling
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = out_cnt;
        target_nxt = target;
        timer_nxt  = timer;

        if (accept_c) begin
            target_nxt = dec_tgt_c;
        end

        if (!cyc) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            timer_nxt = '0;
        end else begin
            if (accept_c && !ret_c) begin
                cnt_nxt = out_cnt + CNT_W'(1);
            end else if (!accept_c && ret_c) begin
                cnt_nxt = out_cnt - CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    timer_nxt = '0;
                    if (accept_c) begin
                        state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_nxt == '0) begin
                        state_nxt = ST_IDLE;
                        timer_nxt = '0;
                    end else if (ret_c || !busy_c) begin
                        timer_nxt = '0;
                    end else if (timeout_hit_c) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt_nxt == '0) begin
                        state_nxt = ST_IDLE;
                        timer_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ecap5_dwbic_decoder.sv
// Wishbone B4 pipelined 1-master to N-slave decoder with error target and timeout.
module ecap5_dwbic_decoder
    import ecap5_dwbic_pkg::*;
#(
    parameter int unsigned NUM_SLAVES      = 2,
    parameter int unsigned SEL_LSB         = 14,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [DAT_W-1:0]                m_wb_adr_i,
    input  logic [DAT_W-1:0]                m_wb_dat_i,
    output logic [DAT_W-1:0]                m_wb_dat_o,
    input  logic [SEL_BYTES-1:0]            m_wb_sel_i,
    input  logic                            m_wb_we_i,
    input  logic                            m_wb_stb_i,
    input  logic                            m_wb_cyc_i,
    output logic                            m_wb_ack_o,
    output logic                            m_wb_err_o,
    output logic                            m_wb_stall_o,
    output logic [DAT_W*NUM_SLAVES-1:0]     s_wb_adr_o,
    output logic [DAT_W*NUM_SLAVES-1:0]     s_wb_dat_o,
    input  logic [DAT_W*NUM_SLAVES-1:0]     s_wb_dat_i,
    output logic [SEL_BYTES*NUM_SLAVES-1:0] s_wb_sel_o,
    output logic [NUM_SLAVES-1:0]           s_wb_we_o,
    output logic [NUM_SLAVES-1:0]           s_wb_stb_o,
    output logic [NUM_SLAVES-1:0]           s_wb_cyc_o,
    input  logic [NUM_SLAVES-1:0]           s_wb_ack_i,
    input  logic [NUM_SLAVES-1:0]           s_wb_stall_i
);

    localparam int unsigned SEL_W = sel_width(NUM_SLAVES);
    localparam int unsigned TGT_W = SEL_W + 1;
    localparam logic [TGT_W-1:0] ERR_TGT  = '1;
    localparam logic [DAT_W-1:0] IDX_MASK = DAT_W'(((64'd1 << SEL_W) - 64'd1) << SEL_LSB);

    wb_req_t          req_c;
    logic [SEL_W-1:0] idx_c;
    logic             hi_zero_c;
    logic             mapped_c;
    logic [TGT_W-1:0] dec_tgt_c;
    logic [TGT_W-1:0] target;
    logic             busy_c;
    logic             draining_c;
    logic             tgt_err_c;
    logic             trk_stall_c;
    logic             err_ack_c;
    logic             sel_stall_c;
    logic             sel_ack_c;
    logic [DAT_W-1:0] sel_dat_c;
    logic             stall_all_c;
    logic             accept_c;
    logic             slave_ack_c;

    assign req_c = '{adr: m_wb_adr_i, dat: m_wb_dat_i, sel: m_wb_sel_i, we: m_wb_we_i};

    // Address decode; anything outside the slave windows goes to the error target
    assign idx_c     = m_wb_adr_i[SEL_LSB +: SEL_W];
    assign hi_zero_c = ((m_wb_adr_i >> (SEL_LSB + SEL_W)) == DAT_W'(0));
    assign mapped_c  = hi_zero_c && (32'(idx_c) < NUM_SLAVES);
    assign dec_tgt_c = mapped_c ? {1'b0, idx_c} : ERR_TGT;

    // Mux the decoded slave's stall and the locked target's ack/data
    always_comb begin
        sel_stall_c = 1'b0;
        sel_ack_c   = 1'b0;
        sel_dat_c   = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (dec_tgt_c == TGT_W'(i)) begin
                sel_stall_c = s_wb_stall_i[i];
            end
            if (target == TGT_W'(i)) begin
                sel_ack_c = s_wb_ack_i[i];
                sel_dat_c = s_wb_dat_i[i*DAT_W +: DAT_W];
            end
        end
    end

    assign stall_all_c = trk_stall_c | sel_stall_c;
    assign accept_c    = m_wb_cyc_i & m_wb_stb_i & ~stall_all_c;
    // Slave acks only count while something is outstanding to a real slave
    assign slave_ack_c = m_wb_cyc_i & busy_c & ~draining_c & ~tgt_err_c & sel_ack_c;

    ecap5_dwbic_tracker #(
        .TGT_W           (TGT_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_tracker (
        .clk         (clk_i),
        .rst_n       (rst_i),
        .cyc         (m_wb_cyc_i),
        .accept_c    (accept_c),
        .dec_tgt_c   (dec_tgt_c),
        .slave_ack_c (slave_ack_c),
        .target      (target),
        .busy_c      (busy_c),
        .draining_c  (draining_c),
        .tgt_err_c   (tgt_err_c),
        .stall_c     (trk_stall_c),
        .err_ack_c   (err_ack_c)
    );

    // Master return path; control outputs are forced idle while reset is held
    assign m_wb_stall_o = rst_i & stall_all_c;
    assign m_wb_ack_o   = rst_i & (slave_ack_c | err_ack_c);
    assign m_wb_err_o   = rst_i & err_ack_c;
    assign m_wb_dat_o   = (busy_c & ~draining_c & ~tgt_err_c) ? sel_dat_c : '0;

    // Per-slave request fan-out with the index field cleared from the address
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
        assign s_wb_adr_o[i*DAT_W +: DAT_W]         = req_c.adr & ~IDX_MASK;
        assign s_wb_dat_o[i*DAT_W +: DAT_W]         = req_c.dat;
        assign s_wb_sel_o[i*SEL_BYTES +: SEL_BYTES] = req_c.sel;
        assign s_wb_we_o[i]  = req_c.we;
        assign s_wb_stb_o[i] = rst_i & m_wb_stb_i & m_wb_cyc_i
                             & (dec_tgt_c == TGT_W'(i)) & ~trk_stall_c;
        assign s_wb_cyc_o[i] = rst_i & m_wb_cyc_i & ~draining_c
                             & ((dec_tgt_c == TGT_W'(i)) | (busy_c & (target == TGT_W'(i))));
    end

endmodule

// File: tb/tb_ecap5_dwbic_decoder.sv
// Directed bench for ecap5_dwbic_decoder: decode table plus multi-cycle sequences.
module tb_ecap5_dwbic_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m_wb_adr_i;
    logic [31:0] m_wb_dat_i;
    logic [31:0] m_wb_dat_o;
    logic [3:0]  m_wb_sel_i;
    logic        m_wb_we_i;
    logic        m_wb_stb_i;
    logic        m_wb_cyc_i;
    logic        m_wb_ack_o;
    logic        m_wb_err_o;
    logic        m_wb_stall_o;
    logic [63:0] s_wb_adr_o;
    logic [63:0] s_wb_dat_o;
    logic [63:0] s_wb_dat_i;
    logic [7:0]  s_wb_sel_o;
    logic [1:0]  s_wb_we_o;
    logic [1:0]  s_wb_stb_o;
    logic [1:0]  s_wb_cyc_o;
    logic [1:0]  s_wb_ack_i;
    logic [1:0]  s_wb_stall_i;

    int checks = 0;
    int errors = 0;

    ecap5_dwbic_decoder #(
        .NUM_SLAVES      (2),
        .SEL_LSB         (14),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .m_wb_adr_i   (m_wb_adr_i),
        .m_wb_dat_i   (m_wb_dat_i),
        .m_wb_dat_o   (m_wb_dat_o),
        .m_wb_sel_i   (m_wb_sel_i),
        .m_wb_we_i    (m_wb_we_i),
        .m_wb_stb_i   (m_wb_stb_i),
        .m_wb_cyc_i   (m_wb_cyc_i),
        .m_wb_ack_o   (m_wb_ack_o),
        .m_wb_err_o   (m_wb_err_o),
        .m_wb_stall_o (m_wb_stall_o),
        .s_wb_adr_o   (s_wb_adr_o),
        .s_wb_dat_o   (s_wb_dat_o),
        .s_wb_dat_i   (s_wb_dat_i),
        .s_wb_sel_o   (s_wb_sel_o),
        .s_wb_we_o    (s_wb_we_o),
        .s_wb_stb_o   (s_wb_stb_o),
        .s_wb_cyc_o   (s_wb_cyc_o),
        .s_wb_ack_i   (s_wb_ack_i),
        .s_wb_stall_i (s_wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] adr;
        logic        stb;
        logic [1:0]  stall_in;
        logic [1:0]  exp_stb;
        logic [1:0]  exp_cyc;
        logic [31:0] exp_adr;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        m_wb_adr_i   = '0;
        m_wb_dat_i   = '0;
        m_wb_sel_i   = 4'hF;
        m_wb_we_i    = 1'b0;
        m_wb_stb_i   = 1'b0;
        m_wb_cyc_i   = 1'b0;
        s_wb_dat_i   = '0;
        s_wb_ack_i   = '0;
        s_wb_stall_i = '0;
    endtask

    // Move to the next drive point, half a period before the active edge
    task automatic nxt();
        @(negedge clk_i);
    endtask

    task automatic req(input logic [31:0] adr, input logic we);
        m_wb_cyc_i = 1'b1;
        m_wb_stb_i = 1'b1;
        m_wb_adr_i = adr;
        m_wb_we_i  = we;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int early;

        vecs[0] = '{32'h0000_0010, 1'b1, 2'b00, 2'b01, 2'b01, 32'h0000_0010, 1'b0};
        vecs[1] = '{32'h0000_4020, 1'b1, 2'b00, 2'b10, 2'b10, 32'h0000_0020, 1'b0};
        vecs[2] = '{32'h0001_0000, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0001_0000, 1'b0};
        vecs[3] = '{32'h0000_8000, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0000_8000, 1'b0};
        vecs[4] = '{32'h0000_7FFC, 1'b1, 2'b00, 2'b10, 2'b10, 32'h0000_3FFC, 1'b0};
        vecs[5] = '{32'h0000_4020, 1'b1, 2'b10, 2'b10, 2'b10, 32'h0000_0020, 1'b1};
        vecs[6] = '{32'h0000_0010, 1'b1, 2'b10, 2'b01, 2'b01, 32'h0000_0010, 1'b0};
        vecs[7] = '{32'h0000_0010, 1'b0, 2'b00, 2'b00, 2'b01, 32'h0000_0010, 1'b0};
        vecs[8] = '{32'hFFFF_FFFC, 1'b1, 2'b11, 2'b00, 2'b00, 32'hFFFF_BFFC, 1'b0};

        idle_in();
        rst_i = 1'b0;
        #2;
        chk("rst_s_cyc", 32'(s_wb_cyc_o), 32'h0);
        chk("rst_s_stb", 32'(s_wb_stb_o), 32'h0);
        chk("rst_ack",   32'(m_wb_ack_o), 32'h0);
        chk("rst_err",   32'(m_wb_err_o), 32'h0);
        chk("rst_stall", 32'(m_wb_stall_o), 32'h0);
        nxt();
        rst_i = 1'b1;

        // Single-cycle decode table; cyc drops before each edge so nothing is accepted
        for (int v = 0; v < 9; v++) begin
            nxt();
            m_wb_cyc_i   = 1'b1;
            m_wb_stb_i   = vecs[v].stb;
            m_wb_adr_i   = vecs[v].adr;
            s_wb_stall_i = vecs[v].stall_in;
            #1;
            chk($sformatf("vec%0d_stb", v),   32'(s_wb_stb_o),   32'(vecs[v].exp_stb));
            chk($sformatf("vec%0d_cyc", v),   32'(s_wb_cyc_o),   32'(vecs[v].exp_cyc));
            chk($sformatf("vec%0d_adr0", v),  s_wb_adr_o[31:0],  vecs[v].exp_adr);
            chk($sformatf("vec%0d_adr1", v),  s_wb_adr_o[63:32], vecs[v].exp_adr);
            chk($sformatf("vec%0d_stall", v), 32'(m_wb_stall_o), 32'(vecs[v].exp_stall));
            m_wb_cyc_i   = 1'b0;
            m_wb_stb_i   = 1'b0;
            s_wb_stall_i = '0;
        end

        // Write to slave0 then read from slave1
        nxt(); req(32'h0000_0010, 1'b1); m_wb_dat_i = 32'hA5A5_A5A5; #1;
        chk("wr_s_stb",   32'(s_wb_stb_o), 32'h1);
        chk("wr_s_adr0",  s_wb_adr_o[31:0], 32'h10);
        chk("wr_s_dat0",  s_wb_dat_o[31:0], 32'hA5A5_A5A5);
        chk("wr_s_we",    32'(s_wb_we_o), 32'h3);
        chk("wr_stall",   32'(m_wb_stall_o), 32'h0);
        nxt(); req(32'h0000_4020, 1'b0); #1;
        chk("rd_blocked_stall", 32'(m_wb_stall_o), 32'h1);
        chk("rd_blocked_stb",   32'(s_wb_stb_o), 32'h0);
        chk("rd_blocked_cyc",   32'(s_wb_cyc_o), 32'h3);
        chk("rd_s_adr1",        s_wb_adr_o[63:32], 32'h20);
        nxt(); s_wb_ack_i = 2'b01; #1;
        chk("wr_ack",        32'(m_wb_ack_o), 32'h1);
        chk("wr_err",        32'(m_wb_err_o), 32'h0);
        chk("wr_ack_stall",  32'(m_wb_stall_o), 32'h1);
        nxt(); s_wb_ack_i = 2'b00; #1;
        chk("rd_go_stall", 32'(m_wb_stall_o), 32'h0);
        chk("rd_go_stb",   32'(s_wb_stb_o), 32'h2);
        chk("rd_go_ack",   32'(m_wb_ack_o), 32'h0);
        nxt(); m_wb_stb_i = 1'b0; s_wb_ack_i = 2'b10;
        s_wb_dat_i = {32'hDEAD_BEEF, 32'h1111_1111}; #1;
        chk("rd_ack", 32'(m_wb_ack_o), 32'h1);
        chk("rd_dat", m_wb_dat_o, 32'hDEAD_BEEF);
        chk("rd_err", 32'(m_wb_err_o), 32'h0);
        nxt(); idle_in();

        // Four pipelined reads fill the outstanding budget; the fifth waits
        for (int k = 0; k < 4; k++) begin
            nxt(); req(32'(k * 4), 1'b0); #1;
            chk($sformatf("burst%0d_stall", k), 32'(m_wb_stall_o), 32'h0);
            chk($sformatf("burst%0d_stb", k),   32'(s_wb_stb_o), 32'h1);
        end
        nxt(); req(32'h10, 1'b0); s_wb_ack_i = 2'b01; s_wb_dat_i = 64'h1000; #1;
        chk("burst_full_stall", 32'(m_wb_stall_o), 32'h1);
        chk("burst_ack0",       32'(m_wb_ack_o), 32'h1);
        chk("burst_dat0",       m_wb_dat_o, 32'h1000);
        nxt(); s_wb_dat_i = 64'h1001; #1;
        chk("burst_fifth_stall", 32'(m_wb_stall_o), 32'h0);
        chk("burst_dat1",        m_wb_dat_o, 32'h1001);
        nxt(); m_wb_stb_i = 1'b0; s_wb_dat_i = 64'h1002; #1;
        chk("burst_ack2", 32'(m_wb_ack_o), 32'h1);
        chk("burst_dat2", m_wb_dat_o, 32'h1002);
        nxt(); s_wb_dat_i = 64'h1003; #1;
        chk("burst_dat3", m_wb_dat_o, 32'h1003);
        nxt(); s_wb_ack_i = 2'b00; #1;
        chk("burst_gap_ack", 32'(m_wb_ack_o), 32'h0);
        nxt(); s_wb_ack_i = 2'b01; s_wb_dat_i = 64'h1004; #1;
        chk("burst_ack4", 32'(m_wb_ack_o), 32'h1);
        chk("burst_dat4", m_wb_dat_o, 32'h1004);
        nxt(); s_wb_ack_i = 2'b00; m_wb_adr_i = 32'h4000; #1;
        chk("burst_done_stall", 32'(m_wb_stall_o), 32'h0);
        chk("burst_done_ack",   32'(m_wb_ack_o), 32'h0);
        nxt(); idle_in();

        // Unmapped read terminates with ack+err from the internal target
        nxt(); req(32'h0001_0000, 1'b0); s_wb_dat_i = {2{32'h5555_5555}}; #1;
        chk("unm_s_cyc", 32'(s_wb_cyc_o), 32'h0);
        chk("unm_stall", 32'(m_wb_stall_o), 32'h0);
        chk("unm_ack0",  32'(m_wb_ack_o), 32'h0);
        nxt(); m_wb_stb_i = 1'b0; #1;
        chk("unm_ack", 32'(m_wb_ack_o), 32'h1);
        chk("unm_err", 32'(m_wb_err_o), 32'h1);
        chk("unm_dat", m_wb_dat_o, 32'h0);
        nxt(); #1;
        chk("unm_once", 32'(m_wb_ack_o | m_wb_err_o), 32'h0);
        nxt(); idle_in();

        // Slave1 never acks: timeout, drain two requests, ignore late ack
        nxt(); req(32'h0000_4000, 1'b0);
        nxt(); req(32'h0000_4004, 1'b0); #1;
        chk("to_second_stall", 32'(m_wb_stall_o), 32'h0);
        early = 0;
        for (int n = 2; n <= 16; n++) begin
            nxt(); m_wb_stb_i = 1'b0; #1;
            if (m_wb_ack_o || m_wb_err_o) early++;
        end
        chk("to_quiet", 32'(early), 32'h0);
        nxt(); #1;
        chk("to_drain_ack0",  32'(m_wb_ack_o), 32'h1);
        chk("to_drain_err0",  32'(m_wb_err_o), 32'h1);
        chk("to_drain_cyc",   32'(s_wb_cyc_o), 32'h0);
        chk("to_drain_stall", 32'(m_wb_stall_o), 32'h1);
        chk("to_drain_dat",   m_wb_dat_o, 32'h0);
        nxt(); s_wb_ack_i = 2'b10; #1;
        chk("to_drain_ack1", 32'(m_wb_ack_o), 32'h1);
        chk("to_drain_err1", 32'(m_wb_err_o), 32'h1);
        nxt(); #1;
        chk("to_late_ack", 32'(m_wb_ack_o | m_wb_err_o), 32'h0);
        nxt(); s_wb_ack_i = 2'b00; req(32'h0000_0010, 1'b0); #1;
        chk("to_next_stb",   32'(s_wb_stb_o), 32'h1);
        chk("to_next_stall", 32'(m_wb_stall_o), 32'h0);
        nxt(); m_wb_stb_i = 1'b0; s_wb_ack_i = 2'b01; s_wb_dat_i = 64'h600D_F00D; #1;
        chk("to_next_ack", 32'(m_wb_ack_o), 32'h1);
        chk("to_next_err", 32'(m_wb_err_o), 32'h0);
        chk("to_next_dat", m_wb_dat_o, 32'h600D_F00D);
        nxt(); idle_in();

        // Master abort with three outstanding
        for (int k = 0; k < 3; k++) begin
            nxt(); req(32'(k * 4), 1'b0);
        end
        nxt(); m_wb_cyc_i = 1'b0; m_wb_stb_i = 1'b0; s_wb_ack_i = 2'b01; #1;
        chk("abort_ack",   32'(m_wb_ack_o), 32'h0);
        chk("abort_s_cyc", 32'(s_wb_cyc_o), 32'h0);
        nxt(); m_wb_cyc_i = 1'b1; m_wb_adr_i = 32'h4000; #1;
        chk("abort_late_ack", 32'(m_wb_ack_o), 32'h0);
        chk("abort_stall",    32'(m_wb_stall_o), 32'h0);
        nxt(); idle_in();

        // Asynchronous reset mid-burst
        nxt(); req(32'h0, 1'b0);
        nxt(); req(32'h4, 1'b0);
        nxt(); req(32'h8, 1'b0); s_wb_ack_i = 2'b01; #1;
        rst_i = 1'b0; #1;
        chk("areset_s_cyc", 32'(s_wb_cyc_o), 32'h0);
        chk("areset_s_stb", 32'(s_wb_stb_o), 32'h0);
        chk("areset_ack",   32'(m_wb_ack_o), 32'h0);
        chk("areset_stall", 32'(m_wb_stall_o), 32'h0);
        nxt(); rst_i = 1'b1; m_wb_stb_i = 1'b0; m_wb_adr_i = 32'h4000; #1;
        chk("post_rst_stall", 32'(m_wb_stall_o), 32'h0);
        chk("post_rst_ack",   32'(m_wb_ack_o), 32'h0);
        chk("post_rst_cyc",   32'(s_wb_cyc_o), 32'h2);
        nxt(); idle_in();

        nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
